// File: rtl/regm_file.sv
// regm_file: register file for the simple processor datapath.
//   One synchronous write port, two registered read ports (A/B) and a
//   per-register pending scoreboard used by issue logic to stall on in-flight
//   writes.
//   A read in the same cycle as a write to the same register returns the new
//   data (write-first bypass).
// Parameters:
//   WIDTH    data bits per register
//   AW       address bits, DEPTH = 2**AW
//   ZERO_REG 1: register 0 reads as zero, is never written and never pending
// Ports:
//   clk, rst_n                      clock / async active-low reset
//   wr_en, wr_addr, wr_data         write port (writeback)
//   rd_en_x, rd_addr_x              read request, x = a|b (decode)
//   rd_data_x, rd_busy_x            registered read data / pending bit
//   pend_set, pend_addr             mark a register pending (issue)
//   pend_any                        OR of all pending bits
module regm_file #(
    parameter int WIDTH    = 16,
    parameter int AW       = 3,
    parameter int ZERO_REG = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en_a,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    output logic             rd_busy_a,
    input  logic             rd_en_b,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             rd_busy_b,
    input  logic             pend_set,
    input  logic [AW-1:0]    pend_addr,
    output logic             pend_any
);
    localparam int DEPTH = 1 << AW;
    localparam int NPORT = 2;

    logic [DEPTH-1:0][WIDTH-1:0] r_mem;
    logic [DEPTH-1:0]            r_pend;
    logic [DEPTH-1:0]            w_pend_nxt;
    logic                        w_wr_ok;
    logic                        w_ps_ok;

    // Read ports folded into packed arrays so both share one generate body.
    logic [NPORT-1:0]            w_rd_en;
    logic [NPORT-1:0][AW-1:0]    w_rd_addr;
    logic [NPORT-1:0][WIDTH-1:0] r_rd_data;
    logic [NPORT-1:0]            r_rd_busy;

    assign w_rd_en   = {rd_en_b, rd_en_a};
    assign w_rd_addr = {rd_addr_b, rd_addr_a};
    assign rd_data_a = r_rd_data[0];
    assign rd_data_b = r_rd_data[1];
    assign rd_busy_a = r_rd_busy[0];
    assign rd_busy_b = r_rd_busy[1];

    // Accesses to a hardwired zero register are filtered here, so neither the
    // storage, the scoreboard nor the bypass path ever sees them.
    assign w_wr_ok = wr_en    && !((ZERO_REG != 0) && (wr_addr   == '0));
    assign w_ps_ok = pend_set && !((ZERO_REG != 0) && (pend_addr == '0));

    // Set is applied after clear so a same-cycle issue to the register being
    // written back leaves it pending.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_wr_ok) w_pend_nxt[wr_addr]   = 1'b0;
        if (w_ps_ok) w_pend_nxt[pend_addr] = 1'b1;
    end

    assign pend_any = |r_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem  <= '0;
            r_pend <= '0;
        end else begin
            if (w_wr_ok) r_mem[wr_addr] <= wr_data;
            r_pend <= w_pend_nxt;
        end
    end

    for (genvar p = 0; p < NPORT; p++) begin : g_rd
        logic             w_zero;
        logic             w_byp;
        logic [WIDTH-1:0] w_val;

        assign w_zero = (ZERO_REG != 0) && (w_rd_addr[p] == '0);
        assign w_byp  = w_wr_ok && (wr_addr == w_rd_addr[p]);
        assign w_val  = w_zero ? '0 : (w_byp ? wr_data : r_mem[w_rd_addr[p]]);

        // Busy reflects the scoreboard as it will be after this edge.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rd_data[p] <= '0;
                r_rd_busy[p] <= 1'b0;
            end else if (w_rd_en[p]) begin
                r_rd_data[p] <= w_val;
                r_rd_busy[p] <= w_pend_nxt[w_rd_addr[p]];
            end
        end
    end

endmodule

// File: tb/tb_regm_file.sv
module tb_regm_file;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for the 16x8 instances (ZERO_REG=0 and ZERO_REG=1).
    logic        wr_en, rd_en_a, rd_en_b, pend_set;
    logic [2:0]  wr_addr, rd_addr_a, rd_addr_b, pend_addr;
    logic [15:0] wr_data;
    logic [15:0] d0_rda, d0_rdb, dz_rda, dz_rdb;
    logic        d0_ba, d0_bb, d0_pa, dz_ba, dz_bb, dz_pa;

    // Stimulus for the 32x32 instance.
    logic        c_wr_en, c_rd_en_a, c_rd_en_b, c_pend_set;
    logic [4:0]  c_wr_addr, c_rd_addr_a, c_rd_addr_b, c_pend_addr;
    logic [31:0] c_wr_data, c_rda, c_rdb;
    logic        c_ba, c_bb, c_pa;

    regm_file #(.WIDTH(16), .AW(3), .ZERO_REG(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(d0_rda), .rd_busy_a(d0_ba),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(d0_rdb), .rd_busy_b(d0_bb),
        .pend_set(pend_set), .pend_addr(pend_addr), .pend_any(d0_pa));

    regm_file #(.WIDTH(16), .AW(3), .ZERO_REG(1)) u_dz (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(dz_rda), .rd_busy_a(dz_ba),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(dz_rdb), .rd_busy_b(dz_bb),
        .pend_set(pend_set), .pend_addr(pend_addr), .pend_any(dz_pa));

    regm_file #(.WIDTH(32), .AW(5), .ZERO_REG(0)) u_d32 (
        .clk(clk), .rst_n(rst_n), .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
        .rd_en_a(c_rd_en_a), .rd_addr_a(c_rd_addr_a), .rd_data_a(c_rda), .rd_busy_a(c_ba),
        .rd_en_b(c_rd_en_b), .rd_addr_b(c_rd_addr_b), .rd_data_b(c_rdb), .rd_busy_b(c_bb),
        .pend_set(c_pend_set), .pend_addr(c_pend_addr), .pend_any(c_pa));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 0; rd_en_a = 0; rd_en_b = 0; pend_set = 0;
        wr_addr = 0; rd_addr_a = 0; rd_addr_b = 0; pend_addr = 0; wr_data = 0;
    endtask

    function automatic logic [31:0] pat(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {16'hC0DE, b, ~b};
    endfunction

    initial begin
        idle();
        c_wr_en = 0; c_rd_en_a = 0; c_rd_en_b = 0; c_pend_set = 0;
        c_wr_addr = 0; c_rd_addr_a = 0; c_rd_addr_b = 0; c_pend_addr = 0; c_wr_data = 0;
        step(); step();
        rst_n = 1'b1;
        step();

        // 1: activity, then asynchronous reset between edges
        wr_en = 1; wr_addr = 1; wr_data = 16'h1234;
        pend_set = 1; pend_addr = 6;
        rd_en_a = 1; rd_addr_a = 1; rd_en_b = 1; rd_addr_b = 6;
        step();
        chk("pre_rst_rda", d0_rda, 32'h1234);
        chk("pre_rst_busyb", d0_bb, 1);
        chk("pre_rst_pend", d0_pa, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rda", d0_rda, 0);
        chk("rst_busyb", d0_bb, 0);
        chk("rst_pend", d0_pa, 0);
        #1 rst_n = 1'b1;
        wr_en = 0; pend_set = 0;
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = i[2:0];
            rd_addr_b = 3'(7 - i);
            step();
            chk($sformatf("rst_rd_a%0d", i), d0_rda, 0);
            chk($sformatf("rst_rd_b%0d", i), d0_rdb, 0);
        end
        idle();

        // 2: write then read, hold when disabled
        wr_en = 1; wr_addr = 3; wr_data = 16'hBEEF;
        step();
        wr_en = 0; rd_en_a = 1; rd_addr_a = 3;
        step();
        chk("wr_rd", d0_rda, 32'hBEEF);
        rd_en_a = 0; rd_addr_a = 0;
        wr_en = 1; wr_addr = 3; wr_data = 16'h0001;
        step();
        chk("hold", d0_rda, 32'hBEEF);
        idle();

        // 3: write-first bypass on both ports
        wr_en = 1; wr_addr = 5; wr_data = 16'h1111;
        step();
        wr_data = 16'h2222;
        rd_en_a = 1; rd_addr_a = 5; rd_en_b = 1; rd_addr_b = 5;
        step();
        chk("byp_a", d0_rda, 32'h2222);
        chk("byp_b", d0_rdb, 32'h2222);
        idle();

        // 4: scoreboard
        pend_set = 1; pend_addr = 2;
        step();
        pend_set = 0;
        chk("pend_any_set", d0_pa, 1);
        rd_en_a = 1; rd_addr_a = 2;
        step();
        chk("busy_r2", d0_ba, 1);
        chk("data_r2_old", d0_rda, 0);
        wr_en = 1; wr_addr = 2; wr_data = 16'h0042;
        step();
        chk("busy_r2_clr", d0_ba, 0);
        chk("data_r2_new", d0_rda, 32'h0042);
        chk("pend_any_clr", d0_pa, 0);
        rd_en_a = 0;
        wr_addr = 4; wr_data = 16'h0777; pend_set = 1; pend_addr = 4;
        rd_en_b = 1; rd_addr_b = 4;
        step();
        chk("same_busy_r4", d0_bb, 1);
        chk("same_data_r4", d0_rdb, 32'h0777);
        chk("same_pend", d0_pa, 1);
        wr_addr = 4; wr_data = 16'h0888; pend_addr = 1;
        rd_en_a = 1; rd_addr_a = 4; rd_addr_b = 1;
        step();
        chk("diff_busy_r4", d0_ba, 0);
        chk("diff_data_r4", d0_rda, 32'h0888);
        chk("diff_busy_r1", d0_bb, 1);
        chk("diff_pend", d0_pa, 1);
        pend_set = 0; rd_en_a = 0; rd_en_b = 0;
        wr_addr = 1; wr_data = 16'h0101;
        step();
        chk("pend_drain", d0_pa, 0);
        idle();

        // 5: register 0 (hardwired in u_dz, ordinary in u_d0)
        wr_en = 1; wr_addr = 0; wr_data = 16'hFFFF;
        pend_set = 1; pend_addr = 0;
        rd_en_a = 1; rd_addr_a = 0; rd_en_b = 1; rd_addr_b = 0;
        step();
        chk("z_byp_data", dz_rda, 0);
        chk("z_busy", dz_ba, 0);
        chk("z_pend", dz_pa, 0);
        chk("r0_byp_data", d0_rda, 32'hFFFF);
        chk("r0_busy", d0_ba, 1);
        chk("r0_pend", d0_pa, 1);
        wr_en = 0; pend_set = 0; rd_en_a = 0;
        step();
        chk("z_rd_data", dz_rdb, 0);
        chk("z_rd_busy", dz_bb, 0);
        chk("r0_rd_data", d0_rdb, 32'hFFFF);
        chk("r0_rd_busy", d0_bb, 1);
        idle();

        // 6: WIDTH=32 AW=5 full sweep
        c_wr_en = 1;
        for (int i = 0; i < 32; i++) begin
            c_wr_addr = i[4:0];
            c_wr_data = pat(i);
            step();
        end
        c_wr_en = 0; c_rd_en_a = 1; c_rd_en_b = 1;
        for (int i = 0; i < 32; i++) begin
            c_rd_addr_a = i[4:0];
            c_rd_addr_b = 5'(31 - i);
            step();
            chk($sformatf("w32_a%0d", i), c_rda, pat(i));
            chk($sformatf("w32_b%0d", 31 - i), c_rdb, pat(31 - i));
        end
        chk("w32_busy", {c_ba, c_bb}, 0);
        chk("w32_pend", c_pa, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
